// File: rtl/laser_job_ctrl_pkg.sv
// Shared types and defaults for the LASER job wrapper: coordinate sizes,
// FSM state encoding and the packed point / result records.
package laser_job_ctrl_pkg;

    localparam int COORD_W     = 4;
    localparam int PT_W        = 2 * COORD_W;
    localparam int CNT_W       = 8;
    localparam int DEF_NUM_PTS = 40;
    localparam int DEF_TO_W    = 16;
    localparam int DEF_TO_MAX  = 40000;

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESULT    = 2'd3
    } state_t;

    // One buffered target point, Y in the upper nibble.
    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } point_t;

    // Latched pair of circle centres returned to the host.
    typedef struct packed {
        logic [COORD_W-1:0] c1x;
        logic [COORD_W-1:0] c1y;
        logic [COORD_W-1:0] c2x;
        logic [COORD_W-1:0] c2y;
    } centres_t;

endpackage

// File: rtl/laser_pt_buf.sv
// Point buffer: NUM_PTS x 8-bit register file, one synchronous write port
// and one combinational read port. Out-of-range reads return zero.
module laser_pt_buf
    import laser_job_ctrl_pkg::*;
#(
    parameter int NUM_PTS = DEF_NUM_PTS,
    parameter int IDX_W   = $clog2(DEF_NUM_PTS + 1)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PT_W-1:0]  wr_pt,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PT_W-1:0]  rd_pt
);

    logic [PT_W-1:0] mem [NUM_PTS];

    // Store the incoming point at the write index.
    // NOTE: storage has no reset; every entry is written before it is read in a job.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_pt;
        end
    end

    assign rd_pt = (rd_idx < IDX_W'(NUM_PTS)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/laser_job_ctrl.sv
// Job wrapper around the LASER two-circle core: collects NUM_PTS points from
// the host, streams them into the core straight out of reset, waits for DONE
// (or a timeout) and hands the latched centres back over valid/ready.
module laser_job_ctrl
    import laser_job_ctrl_pkg::*;
#(
    parameter int NUM_PTS = DEF_NUM_PTS,
    parameter int TO_W    = DEF_TO_W,
    parameter int TO_MAX  = DEF_TO_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               core_rst,
    output logic [COORD_W-1:0] core_x,
    output logic [COORD_W-1:0] core_y,
    input  logic [COORD_W-1:0] core_c1x,
    input  logic [COORD_W-1:0] core_c1y,
    input  logic [COORD_W-1:0] core_c2x,
    input  logic [COORD_W-1:0] core_c2y,
    input  logic               core_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_c1x,
    output logic [COORD_W-1:0] out_c1y,
    output logic [COORD_W-1:0] out_c2x,
    output logic [COORD_W-1:0] out_c2y,
    output logic               out_err,
    output logic [CNT_W-1:0]   job_cnt
);

    localparam int              IDX_W    = $clog2(NUM_PTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);
    localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NUM_PTS);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_MAX - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [TO_W-1:0]  to_cnt;
    logic             wr_en;
    point_t           wr_pt;
    point_t           rd_pt;
    centres_t         out_c;

    assign wr_en = (state == ST_LOAD) && in_valid && in_ready;
    assign wr_pt = {in_y, in_x};

    laser_pt_buf #(
        .NUM_PTS (NUM_PTS),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_pt  (wr_pt),
        .rd_idx (rd_idx),
        .rd_pt  (rd_pt)
    );

    assign out_c1x = out_c.c1x;
    assign out_c1y = out_c.c1y;
    assign out_c2x = out_c.c2x;
    assign out_c2y = out_c.c2y;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: LOAD -> STREAM -> WAIT_DONE -> RESULT -> LOAD.
    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD:      if (wr_en && (wr_idx == LAST_IDX)) next_state = ST_STREAM;
            ST_STREAM:    if (rd_idx == END_IDX) next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: if (core_done || (to_cnt == TO_LAST)) next_state = ST_RESULT;
            ST_RESULT:    if (out_valid && out_ready) next_state = ST_LOAD;
            default:      next_state = ST_LOAD;
        endcase
    end

    // Datapath: indices, core drive, timeout counter, result capture and job count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            to_cnt    <= '0;
            core_rst  <= 1'b1;
            core_x    <= '0;
            core_y    <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            out_err   <= 1'b0;
            job_cnt   <= '0;
        end else begin
            // Host may only push points while the next cycle is a LOAD cycle.
            in_ready <= (next_state == ST_LOAD);
            case (state)
                ST_LOAD: begin
                    if (wr_en) begin
                        wr_idx <= wr_idx + IDX_W'(1);
                    end
                    // Release the core and present point 0 on the same edge.
                    if (next_state == ST_STREAM) begin
                        core_rst <= 1'b0;
                        core_x   <= rd_pt.x;
                        core_y   <= rd_pt.y;
                        rd_idx   <= rd_idx + IDX_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (rd_idx == END_IDX) begin
                        core_x <= '0;
                        core_y <= '0;
                    end else begin
                        core_x <= rd_pt.x;
                        core_y <= rd_pt.y;
                        rd_idx <= rd_idx + IDX_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    // DONE takes priority over a timeout on the same cycle.
                    if (core_done) begin
                        out_c     <= {core_c1x, core_c1y, core_c2x, core_c2y};
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        core_rst  <= 1'b1;
                        job_cnt   <= job_cnt + CNT_W'(1);
                    end else if (to_cnt == TO_LAST) begin
                        out_c     <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        core_rst  <= 1'b1;
                        job_cnt   <= job_cnt + CNT_W'(1);
                    end
                end
                ST_RESULT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        wr_idx    <= '0;
                        rd_idx    <= '0;
                        to_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_job_ctrl.sv
// Directed bench for laser_job_ctrl: a table of jobs (point pattern, host
// valid style, core DONE timing, expected result) plus hand-written sequences
// for mid-job reset and job counter wrap.
module tb_laser_job_ctrl;

    localparam int NUM_PTS = 40;
    localparam int TO_MAX  = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_x = '0;
    logic [3:0] in_y = '0;
    logic       core_rst;
    logic [3:0] core_x, core_y;
    logic [3:0] core_c1x = '0, core_c1y = '0, core_c2x = '0, core_c2y = '0;
    logic       core_done = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_c1x, out_c1y, out_c2x, out_c2y;
    logic       out_err;
    logic [7:0] job_cnt;

    int total = 0;
    int bad   = 0;

    logic [3:0] px [NUM_PTS];
    logic [3:0] py [NUM_PTS];

    typedef struct {
        int         mode;      // 0: back-to-back valid, 1: random valid + stray DONE during load
        int         seed;      // point pattern
        int         done_dly;  // WAIT_DONE cycle on which DONE is pulsed, -1 = never
        int         hold;      // cycles OUT_READY stays low
        logic [3:0] c1x, c1y, c2x, c2y;
        logic       exp_err;
        logic [3:0] e1x, e1y, e2x, e2y;
        logic [7:0] exp_cnt;
    } job_vec_t;

    laser_job_ctrl #(
        .NUM_PTS (NUM_PTS),
        .TO_W    (16),
        .TO_MAX  (TO_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .core_rst  (core_rst),
        .core_x    (core_x),
        .core_y    (core_y),
        .core_c1x  (core_c1x),
        .core_c1y  (core_c1y),
        .core_c2x  (core_c2x),
        .core_c2y  (core_c2y),
        .core_done (core_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c1x   (out_c1x),
        .out_c1y   (out_c1y),
        .out_c2x   (out_c2x),
        .out_c2y   (out_c2y),
        .out_err   (out_err),
        .job_cnt   (job_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic gen_pts(input int seed);
        for (int i = 0; i < NUM_PTS; i++) begin
            px[i] = 4'((i + seed) % 16);
            py[i] = 4'((3 * i + 2 * seed) % 16);
        end
    endtask

    task automatic randomize_core_results();
        core_c1x = 4'($urandom);
        core_c1y = 4'($urandom);
        core_c2x = 4'($urandom);
        core_c2y = 4'($urandom);
    endtask

    // Push all points; called and returns on a falling edge. Returns at the
    // first falling edge after the last handshake.
    task automatic load_pts(input int mode);
        int n = 0;
        int guard = 0;
        while (n < NUM_PTS && guard < 8 * NUM_PTS) begin
            if (mode == 0 || $urandom_range(1, 0) == 1) begin
                in_valid = 1'b1;
                in_x = px[n];
                in_y = py[n];
            end else begin
                in_valid = 1'b0;
                in_x = 4'($urandom);
                in_y = 4'($urandom);
            end
            if (mode == 1) begin
                core_done = 1'($urandom_range(1, 0));
                randomize_core_results();
            end
            if (in_valid && in_ready) n++;
            @(negedge clk);
            guard++;
        end
        check("load_handshakes", n, NUM_PTS);
        core_done = 1'b0;
        // Keep IN_VALID asserted with junk through the rest of the job.
        in_valid = 1'b1;
        in_x = 4'($urandom);
        in_y = 4'($urandom);
    endtask

    // Check the first nstop streamed points; returns on the falling edge
    // where point nstop should be on CORE_X/Y.
    task automatic stream_pts(input int nstop);
        check("core_rst_released", core_rst, 1'b0);
        for (int k = 0; k < nstop; k++) begin
            check($sformatf("core_x[%0d]", k), core_x, px[k]);
            check($sformatf("core_y[%0d]", k), core_y, py[k]);
            check($sformatf("stream_rst[%0d]", k), core_rst, 1'b0);
            check($sformatf("stream_in_ready[%0d]", k), in_ready, 1'b0);
            in_x = 4'($urandom);
            in_y = 4'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic run_job(input job_vec_t v);
        int cyc = 0;
        bit seen = 0;
        int exp_cyc;
        gen_pts(v.seed);
        load_pts(v.mode);
        stream_pts(NUM_PTS);
        check("wait_core_x_zero", core_x, 4'd0);
        check("wait_core_y_zero", core_y, 4'd0);
        check("wait_in_ready", in_ready, 1'b0);
        while (!seen && cyc < TO_MAX + 5) begin
            if (out_valid) begin
                seen = 1;
            end else begin
                core_done = (cyc == v.done_dly);
                if (cyc == v.done_dly) begin
                    core_c1x = v.c1x; core_c1y = v.c1y;
                    core_c2x = v.c2x; core_c2y = v.c2y;
                end else begin
                    randomize_core_results();
                end
                @(negedge clk);
                cyc++;
            end
        end
        core_done = 1'b0;
        exp_cyc = (v.done_dly >= 0) ? v.done_dly + 1 : TO_MAX;
        check("wait_cycles", cyc, exp_cyc);
        check("out_valid", out_valid, 1'b1);
        check("core_rst_reasserted", core_rst, 1'b1);
        check("result_in_ready", in_ready, 1'b0);
        for (int h = 0; h <= v.hold; h++) begin
            check("out_err", out_err, v.exp_err);
            check("out_c1x", out_c1x, v.e1x);
            check("out_c1y", out_c1y, v.e1y);
            check("out_c2x", out_c2x, v.e2x);
            check("out_c2y", out_c2y, v.e2y);
            check("job_cnt", job_cnt, v.exp_cnt);
            check("out_valid_held", out_valid, 1'b1);
            if (h < v.hold) begin
                out_ready = 1'b0;
                core_done = 1'($urandom_range(1, 0));
                randomize_core_results();
                @(negedge clk);
            end
        end
        core_done = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_cleared", out_valid, 1'b0);
        check("next_in_ready", in_ready, 1'b1);
        check("job_cnt_after", job_cnt, v.exp_cnt);
    endtask

    job_vec_t vecs [4];
    job_vec_t wv;

    initial begin
        vecs[0] = '{0, 0, 0, 10, 4'd3, 4'd5, 4'd12, 4'd9, 1'b0, 4'd3, 4'd5, 4'd12, 4'd9, 8'd1};
        vecs[1] = '{1, 3, 5, 2, 4'd15, 4'd0, 4'd1, 4'd14, 1'b0, 4'd15, 4'd0, 4'd1, 4'd14, 8'd2};
        vecs[2] = '{1, 7, -1, 3, 4'd7, 4'd7, 4'd7, 4'd7, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 8'd3};
        vecs[3] = '{0, 11, TO_MAX - 1, 1, 4'd10, 4'd11, 4'd4, 4'd2, 1'b0, 4'd10, 4'd11, 4'd4, 4'd2, 8'd4};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_core_x", core_x, 4'd0);
        check("rst_core_y", core_y, 4'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_c", {out_c1x, out_c1y, out_c2x, out_c2y}, 16'h0);
        check("rst_job_cnt", job_cnt, 8'd0);
        rst_n = 1'b1;
        check("release_in_ready", in_ready, 1'b0);
        @(negedge clk);
        check("first_in_ready", in_ready, 1'b1);

        // Table of jobs: normal, random valid, timeout, DONE on the timeout cycle.
        for (int j = 0; j < 4; j++) begin
            run_job(vecs[j]);
        end

        // Reset in the middle of streaming, then a fresh job.
        gen_pts(5);
        load_pts(0);
        stream_pts(17);
        check("pre_reset_core_x17", core_x, px[17]);
        rst_n = 1'b0;
        #1;
        check("midrst_core_rst", core_rst, 1'b1);
        check("midrst_core_x", core_x, 4'd0);
        check("midrst_core_y", core_y, 4'd0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_job_cnt", job_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", in_ready, 1'b1);
        check("postrst_job_cnt", job_cnt, 8'd0);
        in_valid = 1'b0;
        wv = '{1, 9, 2, 0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 8'd1};
        run_job(wv);

        // 255 more jobs: the 256th job since reset wraps JOB_CNT to 0.
        for (int k = 0; k < 255; k++) begin
            wv = '{0, k, k % 3, 0, 4'(k), 4'(k + 1), 4'(k + 2), 4'(k + 3), 1'b0,
                   4'(k), 4'(k + 1), 4'(k + 2), 4'(k + 3), 8'(k + 2)};
            run_job(wv);
        end
        check("job_cnt_wrap", job_cnt, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
